// File: rtl/guarded_counter_supervisor.sv
// guarded_counter_supervisor
//   Sequences one guarded counter: holds its reset low for RST_CYCLES, checks
//   that it comes out of reset at zero, then checks every cycle that the count
//   steps by exactly one and that its guard parity bits match the count.
//   On an error it pulses fault, re-primes the counter up to MAX_RETRY times,
//   then locks out until clear.
//
// Ports
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   start            begin supervision (sampled in IDLE only)
//   stop             RUN -> IDLE (ignored elsewhere)
//   clear            IDLE/LOCK: zero err_count, LOCK -> IDLE; wins over start
//   cnt_in/guard_in  counter value and its guard bits
//   cnt_rstn         active-low reset to the counter
//   busy             high in PRIME, SETTLE, RUN, FAULT
//   fault            one-cycle pulse per detected error
//   locked           high in LOCK
//   err_count        saturating error total
//
// Optional feature: define GUARD_SUP_SNAPSHOT_EN to add snap_cnt/snap_guard,
//   which capture cnt_in/guard_in on each detected error.
module guarded_counter_supervisor #(
  parameter int WIDTH      = 8,
  parameter int GUARD_BITS = 2,
  parameter int MAX_RETRY  = 2,
  parameter int RST_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      cnt_in,
  input  logic [GUARD_BITS-1:0] guard_in,
  output logic                  cnt_rstn,
  output logic                  busy,
  output logic                  fault,
  output logic                  locked,
  output logic [7:0]            err_count
`ifdef GUARD_SUP_SNAPSHOT_EN
  ,
  output logic [WIDTH-1:0]      snap_cnt,
  output logic [GUARD_BITS-1:0] snap_guard
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_SETTLE, S_RUN, S_FAULT, S_LOCK
  } state_e;

  localparam logic [3:0] RST_LAST  = 4'(RST_CYCLES - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  state_e          state_q, state_d;
  logic [3:0]      retry_q, retry_d;
  logic [3:0]      pcnt_q, pcnt_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [7:0]      err_q, err_d;
  logic            cnt_rstn_q, cnt_rstn_d;
  logic            busy_q, busy_d;
  logic            fault_q, fault_d;
  logic            locked_q, locked_d;
`ifdef GUARD_SUP_SNAPSHOT_EN
  logic [WIDTH-1:0]      snap_cnt_q, snap_cnt_d;
  logic [GUARD_BITS-1:0] snap_guard_q, snap_guard_d;
`endif

  // Expected guard: bit g is the XOR of every count bit whose index is g mod GUARD_BITS.
  logic [GUARD_BITS-1:0] exp_guard;
  for (genvar g = 0; g < GUARD_BITS; g++) begin : g_guard
    logic [WIDTH-1:0] mask;
    always_comb begin
      mask = '0;
      for (int i = g; i < WIDTH; i += GUARD_BITS) mask[i] = 1'b1;
    end
    assign exp_guard[g] = ^(cnt_in & mask);
  end

  // SETTLE expects a freshly reset counter; RUN expects prev+1 (wraps naturally).
  logic [WIDTH-1:0] exp_cnt;
  logic             chk_err;
  assign exp_cnt = (state_q == S_SETTLE) ? '0 : prev_q + 1'b1;
  assign chk_err = (exp_guard != guard_in) || (cnt_in != exp_cnt);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    pcnt_d  = pcnt_q;
    prev_d  = prev_q;
    err_d   = err_q;
`ifdef GUARD_SUP_SNAPSHOT_EN
    snap_cnt_d   = snap_cnt_q;
    snap_guard_d = snap_guard_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (clear) begin
          err_d = '0;
`ifdef GUARD_SUP_SNAPSHOT_EN
          snap_cnt_d   = '0;
          snap_guard_d = '0;
`endif
        end else if (start) begin
          state_d = S_PRIME;
          retry_d = '0;
          pcnt_d  = '0;
        end
      end
      S_PRIME: begin
        if (pcnt_q == RST_LAST) state_d = S_SETTLE;
        else                    pcnt_d  = pcnt_q + 4'd1;
      end
      S_SETTLE, S_RUN: begin
        // An error always wins over stop on the same cycle.
        if (chk_err) begin
          state_d = S_FAULT;
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
`ifdef GUARD_SUP_SNAPSHOT_EN
          snap_cnt_d   = cnt_in;
          snap_guard_d = guard_in;
`endif
        end else begin
          prev_d = cnt_in;
          if (state_q == S_SETTLE) state_d = S_RUN;
          else if (stop)           state_d = S_IDLE;
        end
      end
      S_FAULT: begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 4'd1;
          pcnt_d  = '0;
          state_d = S_PRIME;
        end else begin
          state_d = S_LOCK;
        end
      end
      S_LOCK: begin
        if (clear) begin
          state_d = S_IDLE;
          err_d   = '0;
`ifdef GUARD_SUP_SNAPSHOT_EN
          snap_cnt_d   = '0;
          snap_guard_d = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered as a decode of the next state, so they line up
    // with the state register.
    cnt_rstn_d = !(state_d inside {S_IDLE, S_PRIME, S_LOCK});
    busy_d     = state_d inside {S_PRIME, S_SETTLE, S_RUN, S_FAULT};
    fault_d    = (state_d == S_FAULT);
    locked_d   = (state_d == S_LOCK);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      retry_q    <= '0;
      pcnt_q     <= '0;
      prev_q     <= '0;
      err_q      <= '0;
      cnt_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      locked_q   <= 1'b0;
`ifdef GUARD_SUP_SNAPSHOT_EN
      snap_cnt_q   <= '0;
      snap_guard_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      pcnt_q     <= pcnt_d;
      prev_q     <= prev_d;
      err_q      <= err_d;
      cnt_rstn_q <= cnt_rstn_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      locked_q   <= locked_d;
`ifdef GUARD_SUP_SNAPSHOT_EN
      snap_cnt_q   <= snap_cnt_d;
      snap_guard_q <= snap_guard_d;
`endif
    end
  end

  assign cnt_rstn  = cnt_rstn_q;
  assign busy      = busy_q;
  assign fault     = fault_q;
  assign locked    = locked_q;
  assign err_count = err_q;
`ifdef GUARD_SUP_SNAPSHOT_EN
  assign snap_cnt   = snap_cnt_q;
  assign snap_guard = snap_guard_q;
`endif

endmodule

// File: tb/tb_guarded_counter_supervisor.sv
// Directed bench for guarded_counter_supervisor with a behavioural counter
// model whose count (skip) and guard bits (gflip) can be corrupted on demand.
module tb_guarded_counter_supervisor;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [7:0] cnt_mdl;
  logic [7:0] skip = 8'd0;
  logic [1:0] gflip = 2'b00;
  logic [7:0] cnt_in;
  logic [1:0] guard_in;
  logic       cnt_rstn, busy, fault, locked;
  logic [7:0] err_count;
`ifdef GUARD_SUP_SNAPSHOT_EN
  logic [7:0] snap_cnt;
  logic [1:0] snap_guard;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  guarded_counter_supervisor dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .clear(clear),
    .cnt_in(cnt_in), .guard_in(guard_in), .cnt_rstn(cnt_rstn), .busy(busy),
    .fault(fault), .locked(locked), .err_count(err_count)
`ifdef GUARD_SUP_SNAPSHOT_EN
    , .snap_cnt(snap_cnt), .snap_guard(snap_guard)
`endif
  );

  // Even guard bit covers even count bits, odd guard bit covers odd count bits.
  function automatic logic [1:0] gfn(input logic [7:0] c);
    return {c[7] ^ c[5] ^ c[3] ^ c[1], c[6] ^ c[4] ^ c[2] ^ c[0]};
  endfunction

  assign cnt_in   = cnt_mdl;
  assign guard_in = gfn(cnt_mdl) ^ gflip;

  always @(posedge clk) begin
    if (!cnt_rstn) cnt_mdl <= 8'd0;
    else           cnt_mdl <= cnt_mdl + 8'd1 + skip;
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // From IDLE at a negedge: ends at the first negedge in RUN (cnt_mdl == 1).
  task automatic start_run();
    start = 1'b1; tick(); start = 1'b0; tick(3);
  endtask

  task automatic wait_cnt(input logic [7:0] v);
    for (int k = 0; k < 400 && cnt_mdl !== v; k++) tick();
    n_chk++;
    if (cnt_mdl !== v) $display("FAIL wait_cnt got=%h exp=%h", cnt_mdl, v); else n_pass++;
  endtask

  task automatic test_reset();
    tick(2);
    n_chk++;
    if ({cnt_rstn, busy, fault, locked, err_count} !== 12'h000)
      $display("FAIL reset_outs got=%h exp=000", {cnt_rstn, busy, fault, locked, err_count});
    else n_pass++;
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_clean();
    int nf;
    nf = 0;
    start = 1'b1; tick(); start = 1'b0;
    n_chk++;
    if ({cnt_rstn, busy} !== 2'b01) $display("FAIL prime1 got=%b exp=01", {cnt_rstn, busy}); else n_pass++;
    tick();
    n_chk++;
    if ({cnt_rstn, busy} !== 2'b01) $display("FAIL prime2 got=%b exp=01", {cnt_rstn, busy}); else n_pass++;
    tick();
    n_chk++;
    if ({cnt_rstn, busy} !== 2'b11) $display("FAIL settle got=%b exp=11", {cnt_rstn, busy}); else n_pass++;
    tick();
    for (int i = 0; i < 300; i++) begin
      if (fault !== 1'b0) nf++;
      tick();
    end
    n_chk++;
    if (nf != 0) $display("FAIL clean_faults got=%0d exp=0", nf); else n_pass++;
    n_chk++;
    if ({busy, err_count} !== 9'h100) $display("FAIL clean_run got=%h exp=100", {busy, err_count}); else n_pass++;
    stop = 1'b1; tick(); stop = 1'b0;
    n_chk++;
    if ({cnt_rstn, busy, locked} !== 3'b000) $display("FAIL stop_idle got=%b exp=000", {cnt_rstn, busy, locked}); else n_pass++;
  endtask

  task automatic test_guard_flip();
    int nf;
    nf = 0;
    start_run();
    wait_cnt(8'h05);
    gflip = 2'b01; tick(); gflip = 2'b00;
    n_chk++;
    if ({fault, err_count} !== {1'b1, 8'd1}) $display("FAIL gflip_fault got=%h exp=101", {fault, err_count}); else n_pass++;
    tick();
    n_chk++;
    if ({fault, cnt_rstn, busy} !== 3'b001) $display("FAIL gflip_prime1 got=%b exp=001", {fault, cnt_rstn, busy}); else n_pass++;
    tick();
    n_chk++;
    if (cnt_rstn !== 1'b0) $display("FAIL gflip_prime2 got=%b exp=0", cnt_rstn); else n_pass++;
    tick();
    n_chk++;
    if (cnt_rstn !== 1'b1) $display("FAIL gflip_settle got=%b exp=1", cnt_rstn); else n_pass++;
    tick();
    for (int i = 0; i < 5; i++) begin
      if (fault !== 1'b0 || busy !== 1'b1) nf++;
      tick();
    end
    n_chk++;
    if (nf != 0) $display("FAIL gflip_resume got=%0d exp=0", nf); else n_pass++;
    stop = 1'b1; tick(); stop = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    n_chk++;
    if ({busy, err_count} !== 9'h000) $display("FAIL idle_clear got=%h exp=000", {busy, err_count}); else n_pass++;
  endtask

  task automatic test_count_skip();
    start_run();
    wait_cnt(8'h10);
    skip = 8'd1; tick(); skip = 8'd0;
    tick();
    n_chk++;
    if ({fault, err_count} !== {1'b1, 8'd1}) $display("FAIL skip_fault got=%h exp=101", {fault, err_count}); else n_pass++;
    tick();
    n_chk++;
    if ({fault, cnt_rstn, busy} !== 3'b001) $display("FAIL skip_reprime got=%b exp=001", {fault, cnt_rstn, busy}); else n_pass++;
    tick(3);
    stop = 1'b1; tick(); stop = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic test_lockout();
    start_run();
    for (int it = 0; it < 3; it++) begin
      gflip = 2'b10; tick(); gflip = 2'b00;
      n_chk++;
      if ({fault, err_count} !== {1'b1, 8'(it + 1)})
        $display("FAIL lock_fault%0d got=%h exp=%h", it, {fault, err_count}, {1'b1, 8'(it + 1)});
      else n_pass++;
      if (it < 2) tick(4);
    end
    tick();
    n_chk++;
    if ({locked, cnt_rstn, busy, err_count} !== {3'b100, 8'd3})
      $display("FAIL lock_state got=%h exp=%h", {locked, cnt_rstn, busy, err_count}, {3'b100, 8'd3});
    else n_pass++;
    start = 1'b1; tick(); start = 1'b0; tick();
    n_chk++;
    if ({locked, busy, err_count} !== {2'b10, 8'd3}) $display("FAIL lock_start got=%h exp=203", {locked, busy, err_count}); else n_pass++;
    clear = 1'b1; tick(); clear = 1'b0;
    n_chk++;
    if ({locked, busy, err_count} !== 10'h000) $display("FAIL lock_clear got=%h exp=000", {locked, busy, err_count}); else n_pass++;
    tick();
    n_chk++;
    if ({locked, busy} !== 2'b00) $display("FAIL lock_idle got=%b exp=00", {locked, busy}); else n_pass++;
  endtask

  task automatic test_simultaneous();
    start_run();
    tick();
    stop = 1'b1; gflip = 2'b01; tick(); stop = 1'b0; gflip = 2'b00;
    n_chk++;
    if ({fault, busy} !== 2'b11) $display("FAIL stop_err got=%b exp=11", {fault, busy}); else n_pass++;
    tick(4);
    stop = 1'b1; tick(); stop = 1'b0;
    n_chk++;
    if ({busy, err_count} !== {1'b0, 8'd1}) $display("FAIL stop_err_idle got=%h exp=001", {busy, err_count}); else n_pass++;
    start = 1'b1; clear = 1'b1; tick(); start = 1'b0; clear = 1'b0;
    n_chk++;
    if ({busy, cnt_rstn, err_count} !== 10'h000) $display("FAIL start_clear got=%h exp=000", {busy, cnt_rstn, err_count}); else n_pass++;
    tick();
    n_chk++;
    if (busy !== 1'b0) $display("FAIL start_clear_idle got=%b exp=0", busy); else n_pass++;
    // Asynchronous reset mid-RUN, with a nonzero error count beforehand.
    start_run();
    gflip = 2'b01; tick(); gflip = 2'b00;
    tick(5);
    #2 rstn = 1'b0;
    #1;
    n_chk++;
    if ({cnt_rstn, busy, fault, locked, err_count} !== 12'h000)
      $display("FAIL async_rst got=%h exp=000", {cnt_rstn, busy, fault, locked, err_count});
    else n_pass++;
    tick(); rstn = 1'b1; tick();
  endtask

`ifdef GUARD_SUP_SNAPSHOT_EN
  task automatic test_snapshot();
    start_run();
    wait_cnt(8'hA7);
    gflip = 2'b11; tick(); gflip = 2'b00;
    n_chk++;
    if ({fault, snap_cnt, snap_guard} !== {1'b1, 8'hA7, 2'b01})
      $display("FAIL snap_load got=%h exp=%h", {fault, snap_cnt, snap_guard}, {1'b1, 8'hA7, 2'b01});
    else n_pass++;
    tick(4);
    n_chk++;
    if ({busy, snap_cnt, snap_guard} !== {1'b1, 8'hA7, 2'b01})
      $display("FAIL snap_hold got=%h exp=%h", {busy, snap_cnt, snap_guard}, {1'b1, 8'hA7, 2'b01});
    else n_pass++;
    stop = 1'b1; tick(); stop = 1'b0;
    clear = 1'b1; tick(); clear = 1'b0;
    n_chk++;
    if ({snap_cnt, snap_guard} !== 10'h000) $display("FAIL snap_clear got=%h exp=000", {snap_cnt, snap_guard}); else n_pass++;
  endtask
`endif

  initial begin
    #2 rstn = 1'b0;
    test_reset();
    test_clean();
    test_guard_flip();
    test_count_skip();
    test_lockout();
    test_simultaneous();
`ifdef GUARD_SUP_SNAPSHOT_EN
    test_snapshot();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
